// File: rtl/char_action_controller.sv
// Per-player move/attack sequencer for the sprite renderer.
// Buttons are synchronised, the attack button is edge-detected into a sticky
// request, and state/position advance only on frame_tick.
// Ports:
//   clk, rst_n             vga_clk and async active-low reset
//   frame_tick             one-cycle pulse per VGA frame
//   btn_left/right/attack  raw button levels (asynchronous to clk)
//   char_state             0 IDLE,1 LEFT,2 RIGHT,3..5 neutral attack,6..8 directional
//   char_x_pos/char_y_pos  sprite top-left position
//   busy                   high in any attack state
//   hit_active             high in either active (hitbox) state
module char_action_controller #(
  parameter int unsigned X_INIT     = 64,
  parameter int unsigned Y_INIT     = 200,
  parameter int unsigned X_MIN      = 10,
  parameter int unsigned X_MAX      = 502,
  parameter int unsigned FWD_STEP   = 3,
  parameter int unsigned BACK_STEP  = 2,
  parameter int unsigned N_START    = 5,
  parameter int unsigned N_ACTIVE   = 2,
  parameter int unsigned N_RECOVERY = 16,
  parameter int unsigned D_START    = 4,
  parameter int unsigned D_ACTIVE   = 3,
  parameter int unsigned D_RECOVERY = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [3:0] char_state,
  output logic [9:0] char_x_pos,
  output logic [9:0] char_y_pos,
  output logic       busy,
  output logic       hit_active
);

  localparam int unsigned XW = 10;
  localparam int unsigned SW = 11;
  localparam int unsigned CW = 5;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_LEFT         = 4'd1,
    ST_RIGHT        = 4'd2,
    ST_ATK_START    = 4'd3,
    ST_ATK_ACTIVE   = 4'd4,
    ST_ATK_RECOVERY = 4'd5,
    ST_DIR_START    = 4'd6,
    ST_DIR_ACTIVE   = 4'd7,
    ST_DIR_RECOVERY = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] y_q;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          hit_q, hit_d;
  logic [2:0]    sync1_q, sync2_q;
  logic          atk_prev_q;

  logic          left_s, right_s, atk_rise;
  logic [SW-1:0] x_wide;
  logic [XW-1:0] x_left, x_right;

  assign left_s   = sync2_q[0];
  assign right_s  = sync2_q[1];
  assign atk_rise = sync2_q[2] & ~atk_prev_q;

  // Candidate positions, computed 11 bits wide so clamping never sees a wrap
  assign x_wide  = SW'(x_q);
  assign x_left  = (x_wide < SW'(X_MIN + BACK_STEP)) ? XW'(X_MIN)
                                                      : XW'(x_wide - SW'(BACK_STEP));
  assign x_right = ((x_wide + SW'(FWD_STEP)) > SW'(X_MAX)) ? XW'(X_MAX)
                                                            : XW'(x_wide + SW'(FWD_STEP));

  // Two-stage synchroniser plus attack edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      atk_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {btn_attack, btn_right, btn_left};
      sync2_q    <= sync1_q;
      atk_prev_q <= sync2_q[2];
    end
  end

  // State, position and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= XW'(X_INIT);
      y_q     <= XW'(Y_INIT);
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_q;
      req_q   <= req_d;
      busy_q  <= busy_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state, request and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    req_d   = req_q;
    busy_d  = 1'b0;
    hit_d   = 1'b0;

    // Request is sticky; edges during an attack are dropped, a tick consumes it
    if (busy_q) begin
      req_d = 1'b0;
    end else if (frame_tick && req_q) begin
      req_d = 1'b0;
    end else if (atk_rise) begin
      req_d = 1'b1;
    end

    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_LEFT, ST_RIGHT: begin
          if (req_q && (left_s || right_s)) begin
            state_d = ST_DIR_START;
            cnt_d   = CW'(D_START - 1);
          end else if (req_q) begin
            state_d = ST_ATK_START;
            cnt_d   = CW'(N_START - 1);
          end else if (left_s && !right_s) begin
            state_d = ST_LEFT;
            x_d     = x_left;
          end else if (right_s && !left_s) begin
            state_d = ST_RIGHT;
            x_d     = x_right;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ATK_START: begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else begin
            state_d = ST_ATK_ACTIVE;
            cnt_d   = CW'(N_ACTIVE - 1);
          end
        end
        ST_ATK_ACTIVE: begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else begin
            state_d = ST_ATK_RECOVERY;
            cnt_d   = CW'(N_RECOVERY - 1);
          end
        end
        ST_DIR_START: begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else begin
            state_d = ST_DIR_ACTIVE;
            cnt_d   = CW'(D_ACTIVE - 1);
          end
        end
        ST_DIR_ACTIVE: begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else begin
            state_d = ST_DIR_RECOVERY;
            cnt_d   = CW'(D_RECOVERY - 1);
          end
        end
        ST_ATK_RECOVERY, ST_DIR_RECOVERY: begin
          // Leaving recovery always lands in IDLE; movement waits for the next tick
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    case (state_d)
      ST_ATK_START, ST_ATK_RECOVERY, ST_DIR_START, ST_DIR_RECOVERY: busy_d = 1'b1;
      ST_ATK_ACTIVE, ST_DIR_ACTIVE: begin
        busy_d = 1'b1;
        hit_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        hit_d  = 1'b0;
      end
    endcase
  end

  assign char_state = state_q;
  assign char_x_pos = x_q;
  assign char_y_pos = y_q;
  assign busy       = busy_q;
  assign hit_active = hit_q;

endmodule

// File: tb/tb_char_action_controller.sv
// Randomised scoreboard bench for char_action_controller.
// Each frame the stimulus side updates a frame-level reference model and queues
// the expected outputs; a monitor pops and compares after every frame_tick.
module tb_char_action_controller;

  localparam int X_INIT = 64, Y_INIT = 200, X_MIN = 10, X_MAX = 502;
  localparam int FWD = 3, BACK = 2;
  localparam int N_S = 5, N_A = 2, N_R = 16, D_S = 4, D_A = 3, D_R = 15;
  localparam int FRAME_CYC = 10;

  typedef struct {
    int st;
    int x;
    bit busy;
    bit hit;
  } exp_t;

  logic       clk, rst_n, frame_tick, btn_left, btn_right, btn_attack;
  logic [3:0] char_state;
  logic [9:0] char_x_pos, char_y_pos;
  logic       busy, hit_active;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  // Reference model: current state, position, pending request, attack schedule
  int   m_st;
  int   m_x;
  bit   m_req;
  int   sched[$];
  exp_t exp_q[$];

  char_action_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_attack (btn_attack),
    .char_state (char_state),
    .char_x_pos (char_x_pos),
    .char_y_pos (char_y_pos),
    .busy       (busy),
    .hit_active (hit_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st  = 0;
    m_x   = X_INIT;
    m_req = 0;
    sched.delete();
  endfunction

  function automatic void plan_attack(input int code, input int s, input int a, input int r);
    for (int i = 0; i < s; i++) sched.push_back(code);
    for (int i = 0; i < a; i++) sched.push_back(code + 1);
    for (int i = 0; i < r; i++) sched.push_back(code + 2);
    sched.push_back(0);
  endfunction

  function automatic void model_tick(input bit l, input bit r);
    if (sched.size() != 0) begin
      m_st = sched.pop_front();
    end else if (m_req) begin
      m_req = 0;
      if (l || r) plan_attack(6, D_S, D_A, D_R);
      else        plan_attack(3, N_S, N_A, N_R);
      m_st = sched.pop_front();
    end else if (l && !r) begin
      m_st = 1;
      m_x  = (m_x - BACK < X_MIN) ? X_MIN : m_x - BACK;
    end else if (r && !l) begin
      m_st = 2;
      m_x  = (m_x + FWD > X_MAX) ? X_MAX : m_x + FWD;
    end else begin
      m_st = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st   = m_st;
    e.x    = m_x;
    e.busy = (m_st >= 3);
    e.hit  = (m_st == 4) || (m_st == 7);
    return e;
  endfunction

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One frame: set direction, optionally pulse attack, then issue the tick
  task automatic do_frame(input bit l, input bit r, input bit atk);
    int used;
    used = 0;
    btn_left  = l;
    btn_right = r;
    if (atk) begin
      btn_attack = 1'b1;
      repeat (3) @(negedge clk);
      btn_attack = 1'b0;
      used = 3;
      if (m_st < 3) m_req = 1;
    end
    repeat (FRAME_CYC - 1 - used) @(negedge clk);
    model_tick(l, r);
    exp_q.push_back(model_out());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic apply_reset();
    repeat (3) @(negedge clk);
    rst_n      = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_attack = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Monitor: outputs are compared one cycle after each tick edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1) begin
        tick_no++;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick%0d no expected entry queued", tick_no);
        end else begin
          e = exp_q.pop_front();
          if (int'(char_state) != e.st || int'(char_x_pos) != e.x ||
              int'(char_y_pos) != Y_INIT || busy !== e.busy || hit_active !== e.hit) begin
            errors++;
            $display("FAIL tick%0d got st=%0d x=%0d y=%0d busy=%0b hit=%0b want st=%0d x=%0d y=%0d busy=%0b hit=%0b",
                     tick_no, char_state, char_x_pos, char_y_pos, busy, hit_active,
                     e.st, e.x, Y_INIT, e.busy, e.hit);
          end
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_attack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_state", int'(char_state), 0);
    check_val("rst_x", int'(char_x_pos), X_INIT);
    check_val("rst_y", int'(char_y_pos), Y_INIT);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_hit", int'(hit_active), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle frames with no input
    for (int i = 0; i < 20; i++) do_frame(0, 0, 0);

    // Walk right 10 frames, then release
    for (int i = 0; i < 10; i++) do_frame(0, 1, 0);
    do_frame(0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("walk_right_x", int'(char_x_pos), 94);

    // Walk left from X_INIT into the left clamp
    apply_reset();
    for (int i = 0; i < 40; i++) do_frame(1, 0, 0);
    repeat (3) @(negedge clk);
    check_val("left_clamp_x", int'(char_x_pos), X_MIN);

    // Right clamp
    for (int i = 0; i < 175; i++) do_frame(0, 1, 0);
    repeat (3) @(negedge clk);
    check_val("right_clamp_x", int'(char_x_pos), X_MAX);

    // Neutral attack with a second press during the active phase
    apply_reset();
    do_frame(0, 0, 1);
    for (int i = 0; i < 25; i++) do_frame(0, 0, (m_st == 4));

    // Directional attack with right held throughout
    apply_reset();
    do_frame(0, 1, 1);
    for (int i = 0; i < 24; i++) do_frame(0, 1, 0);

    // Both buttons held: no movement
    for (int i = 0; i < 3; i++) do_frame(1, 1, 0);

    // Randomised frames
    for (int i = 0; i < 300; i++) begin
      bit l, r, a;
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      a = ($urandom_range(0, 6) == 0);
      do_frame(l, r, a);
    end

    // Asynchronous reset in the directional active phase
    apply_reset();
    do_frame(1, 0, 1);
    for (int i = 0; i < 10 && m_st != 7; i++) do_frame(1, 0, 0);
    repeat (3) @(negedge clk);
    check_val("pre_reset_state", int'(char_state), 7);
    check_val("pre_reset_hit", int'(hit_active), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_state", int'(char_state), 0);
    check_val("async_rst_x", int'(char_x_pos), X_INIT);
    check_val("async_rst_hit", int'(hit_active), 0);
    check_val("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    btn_left = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) do_frame(0, 0, 0);

    repeat (4) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
